// File: rtl/kgp_pkg.sv
// Shared KGPRISC definitions for the PC/sequencing unit: control-flow opcodes,
// branch flag selection and opcode classification helpers.
package kgp_pkg;

    localparam logic [5:0] OP_CALL = 6'b000110;
    localparam logic [5:0] OP_RET  = 6'b000111;
    localparam logic [5:0] OP_B    = 6'b010000;
    localparam logic [5:0] OP_BR   = 6'b010001;
    localparam logic [5:0] OP_BZ   = 6'b010010;
    localparam logic [5:0] OP_BNZ  = 6'b010011;
    localparam logic [5:0] OP_BCY  = 6'b010100;
    localparam logic [5:0] OP_BNCY = 6'b010101;
    localparam logic [5:0] OP_BS   = 6'b010110;
    localparam logic [5:0] OP_BNS  = 6'b010111;
    localparam logic [5:0] OP_BV   = 6'b011000;
    localparam logic [5:0] OP_BNV  = 6'b011001;

    typedef enum logic [2:0] {
        FLAG_NONE,
        FLAG_Z,
        FLAG_C,
        FLAG_S,
        FLAG_V
    } flag_sel_e;

    function automatic logic is_cond_branch(input logic [5:0] op);
        return (op >= OP_BZ) && (op <= OP_BNV);
    endfunction

    // Conditional branches come in pairs; the odd opcode of each pair tests the inverted flag.
    function automatic flag_sel_e cond_flag(input logic [5:0] op);
        flag_sel_e sel;
        case (op)
            OP_BZ,  OP_BNZ:  sel = FLAG_Z;
            OP_BCY, OP_BNCY: sel = FLAG_C;
            OP_BS,  OP_BNS:  sel = FLAG_S;
            OP_BV,  OP_BNV:  sel = FLAG_V;
            default:         sel = FLAG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a flush empties it while suppressing any push or pop in the same cycle.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            empty_o,
    output logic            full_o,
    output logic            ovf_o,
    output logic            unf_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   top_q, top_d, top_m1;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign top_m1  = top_q - PW'(1);
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(RAS_DEPTH));
    assign rdata_o = mem_q[top_m1];

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !push_i && !flush_i && !empty_o;
    assign ovf_o   = do_push && full_o;
    assign unf_o   = pop_i && !push_i && !flush_i && empty_o;

    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            top_d = '0;
            cnt_d = '0;
        end else if (do_push) begin
            top_d = top_q + PW'(1);
            if (!full_o) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (do_pop) begin
            top_d = top_m1;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents need no reset; gating on rst keeps a reset edge from half-completing a push.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[top_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// KGPRISC program counter and branch sequencer: resolves branch/call/return targets,
// drives the return-address stack and keeps taken, misalign and sticky RAS error state.
module pc_seq_unit
    import kgp_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              RAS_DEPTH   = 8,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic [5:0]      opcode_i,
    input  logic [XLEN-1:0] rd1_i,
    input  logic [XLEN-1:0] label_i,
    input  logic [XLEN-1:0] ra_i,
    input  logic            zflag_i,
    input  logic            carryflag_i,
    input  logic            signflag_i,
    input  logic            overflowflag_i,
    input  logic            ras_flush_i,
    input  logic            err_clr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] link_addr_o,
    output logic            taken_o,
    output logic            misalign_o,
    output logic            ras_empty_o,
    output logic            ras_full_o,
    output logic            ras_err_o
);

    localparam logic [XLEN-1:0] INC        = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    logic [XLEN-1:0] pc_q, pc_d, link_q, link_d;
    logic            taken_q, taken_d, mis_q, mis_d, err_q, err_d;
    logic [XLEN-1:0] seq_pc, target, ras_rdata;
    logic            redirect, flag_val, ras_push, ras_pop, ras_ovf, ras_unf;

    assign seq_pc = pc_q + INC;

    always_comb begin
        flag_val = 1'b0;
        case (cond_flag(opcode_i))
            FLAG_Z:  flag_val = zflag_i;
            FLAG_C:  flag_val = carryflag_i;
            FLAG_S:  flag_val = signflag_i;
            FLAG_V:  flag_val = overflowflag_i;
            default: flag_val = 1'b0;
        endcase
    end

    // A ret falls back to the architectural ra when the stack is empty or being flushed.
    always_comb begin
        redirect = 1'b0;
        target   = label_i;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        case (opcode_i)
            OP_B:  redirect = 1'b1;
            OP_BR: begin
                redirect = 1'b1;
                target   = rd1_i;
            end
            OP_CALL: begin
                redirect = 1'b1;
                ras_push = en_i;
            end
            OP_RET: begin
                redirect = 1'b1;
                ras_pop  = en_i;
                target   = (ras_flush_i || ras_empty_o) ? ra_i : ras_rdata;
            end
            default: redirect = is_cond_branch(opcode_i) && (flag_val ^ opcode_i[0]);
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        link_d  = link_q;
        taken_d = 1'b0;
        mis_d   = 1'b0;
        if (en_i) begin
            pc_d    = redirect ? (target & ~ALIGN_MASK) : seq_pc;
            taken_d = redirect;
            mis_d   = redirect && ((target & ALIGN_MASK) != '0);
            if (opcode_i == OP_CALL) begin
                link_d = seq_pc;
            end
        end
        err_d = (ras_ovf || ras_unf) ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            link_q  <= '0;
            taken_q <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            link_q  <= link_d;
            taken_q <= taken_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .flush_i (ras_flush_i),
        .wdata_i (seq_pc),
        .rdata_o (ras_rdata),
        .empty_o (ras_empty_o),
        .full_o  (ras_full_o),
        .ovf_o   (ras_ovf),
        .unf_o   (ras_unf)
    );

    assign pc_o        = pc_q;
    assign link_addr_o = link_q;
    assign taken_o     = taken_q;
    assign misalign_o  = mis_q;
    assign ras_err_o   = err_q;

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised successor to the single-cycle program-counter/branch block of the KGPRISC core.
- Holds the architectural PC and evaluates all branch, call and return opcodes against the ALU flags.
- Adds a hardware return-address stack (RAS), a stall/enable handshake, a stack flush, target alignment checking and sticky error reporting.
- Sits between decode/ALU-flag outputs and the instruction-memory address port.

Parameters:
- XLEN, 32, width of the PC, targets and link address.
- RAS_DEPTH, 8, return-address stack entries; must be a power of 2 and at least 2.
- RESET_PC, 0, PC value loaded on reset.
- INSTR_BYTES, 4, sequential increment.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  advance enable; 0 = stall, all state held.
- opcode  in  6  instruction opcode; same encoding as the core ISA.
- rd1  in  XLEN  register target for br.
- label  in  XLEN  immediate or absolute target.
- ra  in  XLEN  architectural return register; fallback target for ret.
- zflag, carryflag, signflag, overflowflag  in  1 each  ALU flags.
- ras_flush  in  1  clears the RAS (context switch or exception).
- err_clr  in  1  clears sticky ras_err.
- pc  out  XLEN  current PC.
- link_addr  out  XLEN  last call's PC+INSTR_BYTES.
- taken  out  1  registered; previous advance was a redirect.
- misalign  out  1  registered one-cycle pulse; target low bits were nonzero.
- ras_empty, ras_full  out  1  combinational from the RAS count.
- ras_err  out  1  sticky overflow or underflow.

Behaviour:
- Reset (asynchronous, active-high): pc=RESET_PC; link_addr=0; taken=0; misalign=0; ras_err=0; RAS count=0; RAS top pointer=0. Entry contents are don't-care.
- en=0: pc, link_addr, RAS and ras_err hold; taken=0 and misalign=0 next cycle. ras_flush and err_clr still act while stalled.
- en=1: pc updates on the same edge (1-cycle latency). Next PC by opcode:
  - 010000 b: label.
  - 010001 br: rd1.
  - 010010 bz / 010011 bnz: label if zflag / !zflag.
  - 010100 bcy / 010101 bncy: label if carryflag / !carryflag.
  - 010110 bs / 010111 bns: label if signflag / !signflag.
  - 011000 bv / 011001 bnv: label if overflowflag / !overflowflag.
  - 000110 call: label; link_addr=pc+INSTR_BYTES; push pc+INSTR_BYTES onto RAS.
  - 000111 ret: pop RAS top if count>0; else use ra and set ras_err.
  - Untaken conditional branches and all other opcodes: pc+INSTR_BYTES.
- taken=1 whenever the next PC came from a target rather than the sequential path.
- Arithmetic is modulo 2^XLEN: pc=2^XLEN-4 increments to 0 with no flag.
- Alignment: a target with nonzero bits [log2(INSTR_BYTES)-1:0] is loaded with those bits cleared; misalign=1 for one cycle.
- RAS is a circular buffer:
  - Push when full: overwrite the oldest entry, count stays at RAS_DEPTH, set ras_err.
  - Pop when empty: count stays 0.
- ras_flush and a call/ret in the same cycle: flush wins. The RAS ends empty and no push or pop occurs; the PC still updates. A ret in that cycle uses ra.
- err_clr and a new error in the same cycle: ras_err=1 (set wins).
- Reset asserted mid-stall or mid-call: all state is cleared immediately; the RAS is not partially updated.

Decomposition:
- Shared package kgp_pkg:
  - Opcode localparams OP_B … OP_RET.
  - Flag-select enum.
  - Function is_cond_branch(opcode).
- Sub-module ras_stack (params XLEN, RAS_DEPTH):
  - Inputs: push, pop, flush, wdata.
  - Outputs: rdata, empty, full, ovf, unf.
  - Same clk and rst.
- The top level handles next-PC selection and error/taken registers only.

Test Plan:
1. Reset then en=1 with opcode=000000 for 4 cycles → pc 0,4,8,12,16; taken=0; ras_empty=1.
2. pc=0x100, bz with zflag=1, label=0x200 → pc=0x200, taken=1. Repeat with zflag=0 → pc=0x204, taken=0.
3. Nested call from 0x10 to 0x80, then call from 0x80 to 0xC0, then ret, then ret (ra=0xDEAD0) → pc 0x80, 0xC0, 0x84, 0x14; link_addr=0x84 after the second call; ras_err=0.
4. RAS_DEPTH=8: 9 calls then 9 rets → ras_full after call 8; ras_err=1 after call 9. Rets return the 8 newest addresses; ret 9 takes ra. After err_clr, ras_err=0.
5. en=0 for 3 cycles with opcode=b, label=0x400 → pc unchanged; then en=1 → pc=0x400. Label 0x402 → pc=0x400, misalign pulses 1.
6. Push 2 entries, then ras_flush with simultaneous ret (ra=0x50) → pc=0x50, ras_empty=1. Assert rst mid-run → pc=RESET_PC immediately, without waiting for a clock edge.
